// File: rtl/weight_loader_master_if.sv
// Wishbone write-master bus bundle between weight_loader_master and its slave.
// Latency: none (wires only). Backpressure: the slave stalls the master by withholding wbm_ack_i.
// Notes: the master drives cycle/strobe/address/data; the slave returns ack.
interface weight_loader_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i
    );
endinterface

// File: rtl/weight_loader_master.sv
// weight_loader_master: buffers weight words and writes NUM_WORDS of them as single Wishbone writes.
// Latency: one FETCH cycle before each write and one GAP cycle after each ack.
// Backpressure: push_ready_o low while the FIFO is full; XFER waits for ack, or aborts
// after TIMEOUT_CYCLES when WEIGHT_LOADER_TIMEOUT_EN is defined.

module wl_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

module weight_loader_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h30003000,
    parameter int          NUM_WORDS      = 16,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          start_i,
    input  logic                          push_valid_i,
    input  logic [31:0]                   push_data_i,
    output logic                          push_ready_o,
    weight_loader_master_if.master        wbm,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [4:0]                    words_done_o
);
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [4:0]      LAST_WORD = 5'(NUM_WORDS);

    if (NUM_WORDS < 1 || NUM_WORDS > 16 || TIMEOUT_CYCLES < 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("weight_loader_master: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_XFER, S_GAP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [4:0]    wdone_q, wdone_d;
    logic          fifo_push, fifo_pop;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          xfer;

`ifdef WEIGHT_LOADER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    assign push_ready_o = (fifo_count < FIFO_FULL);
    assign fifo_push    = push_valid_i && push_ready_o;

    wl_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_data_i),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    // idx wraps to 0 after the 16th word; the 5-bit words_done carries the terminal compare.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wdone_d  = wdone_q;
        fifo_pop = 1'b0;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    wdone_d = '0;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_FETCH: begin
`ifdef WEIGHT_LOADER_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (fifo_count != '0) state_d = S_XFER;
            end
            S_XFER: begin
                if (wbm.wbm_ack_i) begin
                    fifo_pop = 1'b1;
                    idx_d    = idx_q + 4'd1;
                    wdone_d  = wdone_q + 5'd1;
                    state_d  = S_GAP;
                end
`ifdef WEIGHT_LOADER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_GAP:   state_d = (wdone_q == LAST_WORD) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wdone_q <= '0;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdone_q <= wdone_d;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    // Bus outputs decode straight from the state register, so they are stable for the whole XFER.
    assign xfer          = (state_q == S_XFER);
    assign wbm.wbm_cyc_o = xfer;
    assign wbm.wbm_stb_o = xfer;
    assign wbm.wbm_we_o  = xfer;
    assign wbm.wbm_sel_o = xfer ? 4'hF : 4'h0;
    assign wbm.wbm_adr_o = xfer ? (BASE_ADDR + {26'd0, idx_q, 2'b00}) : 32'd0;
    assign wbm.wbm_dat_o = xfer ? fifo_head : 32'd0;

    assign busy_o       = (state_q == S_FETCH) || xfer || (state_q == S_GAP);
    assign done_o       = (state_q == S_DONE);
    assign words_done_o = wdone_q;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_weight_loader_master.sv
// Bench for weight_loader_master: random slave ack timing, queue-based model of FIFO and load progress.
module tb_weight_loader_master;
    localparam logic [31:0] BASE  = 32'h30003000;
    localparam int          NW    = 16;
    localparam int          DEPTH = 4;
    localparam int          TMO   = 15;

    logic        clk = 1'b0;
    logic        rst, start, push_valid;
    logic [31:0] push_data;
    logic        push_ready, busy, done, err;
    logic [4:0]  words_done;

    weight_loader_master_if bus();

    weight_loader_master #(
        .BASE_ADDR(BASE), .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .push_ready_o (push_ready),
        .wbm          (bus),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .words_done_o (words_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- slave: 0 = ack next cycle, 1 = random delay, 2 = never ----------------
    int ack_mode = 0;
    bit spur = 1'b0;
    initial begin
        bus.wbm_ack_i = 1'b0;
        forever begin
            tick();
            if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                case (ack_mode)
                    0:       bus.wbm_ack_i = 1'b1;
                    1:       bus.wbm_ack_i = ($urandom_range(0, 2) == 0);
                    default: bus.wbm_ack_i = 1'b0;
                endcase
            end else begin
                bus.wbm_ack_i = spur && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] mq[$];
    bit          chk_en = 1'b0;
    bit          m_active, m_gap, m_done, m_err, prev_hold;
    int          m_idx, m_xcnt;
    int          done_cnt = 0;
    int          ack_cnt = 0;
    logic [31:0] first_adr, last_adr, last_dat;

    always @(negedge clk) begin : cmp
        bit pop, tmo, acc, idle_now, nxt_done;
        if (chk_en) begin
            chk("push_ready", 32'(push_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("words_done", 32'(words_done), 32'(m_idx));
            if (prev_hold) chk("cyc_hold", 32'(bus.wbm_cyc_o), 32'd1);
            if (bus.wbm_cyc_o) begin
                chk("xfer_legal", 32'({m_active, m_gap, mq.size() > 0, m_idx < NW}), 32'b1011);
                chk("stb_we_sel", 32'({bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}), 32'h3F);
                chk("adr", bus.wbm_adr_o, BASE + 32'(4 * m_idx));
                if (mq.size() > 0) chk("dat", bus.wbm_dat_o, mq[0]);
            end else begin
                chk("idle_ctl", 32'({bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}), 32'd0);
                chk("idle_adr", bus.wbm_adr_o, 32'd0);
                chk("idle_dat", bus.wbm_dat_o, 32'd0);
            end
        end
        if (rst) begin
            mq.delete();
            m_active = 0; m_gap = 0; m_done = 0; m_err = 0; prev_hold = 0;
            m_idx = 0; m_xcnt = 0;
        end else begin
            pop = bus.wbm_cyc_o && bus.wbm_ack_i;
            tmo = 1'b0;
`ifdef WEIGHT_LOADER_TIMEOUT_EN
            tmo = bus.wbm_cyc_o && !bus.wbm_ack_i && (m_xcnt == TMO - 1);
`endif
            acc      = push_valid && (mq.size() < DEPTH);
            idle_now = !m_active && !m_done;
            nxt_done = m_gap && (m_idx == NW);
            if (done) done_cnt++;
            if (pop && mq.size() > 0) begin
                if (m_idx == 0) first_adr = bus.wbm_adr_o;
                last_adr = bus.wbm_adr_o;
                last_dat = bus.wbm_dat_o;
                ack_cnt++;
                void'(mq.pop_front());
                m_idx++;
            end
            if (acc) mq.push_back(push_data);
            if (nxt_done || tmo) m_active = 0;
            if (tmo) m_err = 1;
            if (start && idle_now) begin
                m_active = 1; m_idx = 0; m_err = 0;
            end
            prev_hold = bus.wbm_cyc_o && !bus.wbm_ack_i && !tmo;
            m_xcnt    = (bus.wbm_cyc_o && !bus.wbm_ack_i) ? m_xcnt + 1 : 0;
            m_gap     = pop;
            m_done    = nxt_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_word(input logic [31:0] d);
        int n = 0;
        push_valid = 1'b1;
        push_data  = d;
        while (!push_ready && n < 400) begin tick(); n++; end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL push_wait actual=stuck required=ready t=%0t", $time);
        end
        tick();
        push_valid = 1'b0;
    endtask

    // gap < 0 means a random 0..3 idle cycles between pushes
    task automatic run_load(input int nw, input logic [31:0] base_val, input int gap, input bit mid);
        fork
            begin
                for (int i = 0; i < nw; i++) begin
                    push_word(base_val + 32'(i));
                    repeat ((gap < 0) ? $urandom_range(0, 3) : gap) tick();
                end
            end
            begin
                int  n  = 0;
                bit  fired = 1'b0;
                int  d0 = done_cnt;
                start = 1'b1; tick(); start = 1'b0;
                while (done_cnt == d0 && n < 3000) begin
                    if (mid && !fired && words_done == 5'd3) begin start = 1'b1; fired = 1'b1; end
                    else start = 1'b0;
                    tick(); n++;
                end
                start = 1'b0;
                if (n >= 3000) begin
                    checks++; errors++;
                    $display("FAIL load_wait actual=no_done required=done t=%0t", $time);
                end
            end
        join
    endtask

    initial begin
        int d0, a0, n;
        rst = 1'b1; start = 1'b0; push_valid = 1'b0; push_data = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_ready", 32'(push_ready), 32'd1);
        chk("rst_wdone", 32'(words_done), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);

        // sixteen words 0..F, prompt slave
        d0 = done_cnt; a0 = ack_cnt;
        run_load(16, 32'd0, 0, 1'b0);
        chk("t1_first_adr", first_adr, 32'h30003000);
        chk("t1_last_adr", last_adr, 32'h3000303C);
        chk("t1_last_dat", last_dat, 32'h0000000F);
        chk("t1_wdone", 32'(words_done), 32'd16);
        chk("t1_acks", 32'(ack_cnt - a0), 32'd16);
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

        // five pushes with no load running: fifth is refused
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1; push_data = 32'hA0 + 32'(i);
            tick();
            if (i == 2) chk("t2_ready_3", 32'(push_ready), 32'd1);
            if (i == 3) chk("t2_ready_full", 32'(push_ready), 32'd0);
        end
        push_valid = 1'b0;
        chk("t2_no_bus", 32'({bus.wbm_cyc_o, busy}), 32'd0);

        // leftover four words plus twelve more, random acks, spurious acks, second start ignored
        ack_mode = 1; spur = 1'b1;
        d0 = done_cnt; a0 = ack_cnt;
        run_load(12, 32'h1000, -1, 1'b1);
        repeat (5) tick();
        chk("t3_first_dat_kept", first_adr, 32'h30003000);
        chk("t3_last_dat", last_dat, 32'h0000100B);
        chk("t3_acks", 32'(ack_cnt - a0), 32'd16);
        chk("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

        // empty FIFO, one word every ten cycles
        ack_mode = 0; spur = 1'b0;
        d0 = done_cnt; a0 = ack_cnt;
        run_load(16, 32'h2000, 9, 1'b0);
        chk("t4_acks", 32'(ack_cnt - a0), 32'd16);
        chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

        // reset while word 7 is on the bus
        d0 = done_cnt;
        fork
            for (int i = 0; i < 8; i++) push_word(32'h3000 + 32'(i));
            begin start = 1'b1; tick(); start = 1'b0; end
        join
        n = 0;
        while (!(bus.wbm_cyc_o && words_done == 5'd7) && n < 500) begin tick(); n++; end
        chk("t5_reached_word7", 32'(n < 500), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_wdone", 32'(words_done), 32'd0);
        chk("t5_ready", 32'(push_ready), 32'd1);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt;
        run_load(16, 32'h4000, -1, 1'b0);
        chk("t5_reload_wdone", 32'(words_done), 32'd16);
        chk("t5_reload_dat", last_dat, 32'h0000400F);
        chk("t5_reload_done", 32'(done_cnt - d0), 32'd1);

`ifdef WEIGHT_LOADER_TIMEOUT_EN
        // slave never acks: abort with sticky error, head word kept
        ack_mode = 2;
        push_word(32'h5000); push_word(32'h5001);
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        chk("t6_abort", 32'(n < 200), 32'd1);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        ack_mode = 0;
        run_load(14, 32'h5002, 0, 1'b0);
        chk("t6_err_cleared", 32'(err), 32'd0);
        chk("t6_first_word", first_adr, 32'h30003000);
        chk("t6_last_dat", last_dat, 32'h0000500F);
`endif

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_loader_master.md
WEIGHT_LOADER_MASTER -- requirements
Module: weight_loader_master

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: wb_clk_i is the single clock and wb_rst_i is the synchronous active-high reset, sampled on the wb_clk_i rising edge.
REQ-002 Parameters SHALL be:
- BASE_ADDR, 32'h30003000, Wishbone byte address of weight word 0.
- NUM_WORDS, 16, weight words per load (range 1..16).
- FIFO_DEPTH, 4, entries in the data FIFO (power of two).
- TIMEOUT_CYCLES, 15, cycles without ack before abort (only with the timeout macro).
REQ-003 Ports SHALL be:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset.
- start_i  in  1  single-cycle load request.
- push_valid_i  in  1  data word offered.
- push_data_i  in  32  weight word (16 x 2-bit entries, entry 0 in [31:30]).
- push_ready_o  out  1  FIFO can accept.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte lanes.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky timeout error.
- words_done_o  out  5  words acknowledged in the current load.

Function
REQ-004 The FIFO SHALL accept a word when push_valid_i and push_ready_o are both high; push_ready_o = (count < FIFO_DEPTH).
REQ-005 A push and a pop in the same cycle SHALL leave count unchanged. A push while full SHALL be refused by push_ready_o = 0.
REQ-006 The FSM SHALL have states IDLE, FETCH, XFER, GAP and DONE.
REQ-007 IDLE: start_i SHALL clear words_done_o and err_o, zero the word index and move to FETCH. start_i in any other state SHALL be ignored.
REQ-008 FETCH: if the FIFO is non-empty, the FSM SHALL move to XFER on the next edge; otherwise it SHALL stay in FETCH.
REQ-009 XFER outputs SHALL be:
- wbm_cyc_o = wbm_stb_o = wbm_we_o = 1.
- wbm_sel_o = 4'hF.
- wbm_adr_o = BASE_ADDR + 4*index.
- wbm_dat_o = FIFO head.
- All of these SHALL stay stable until ack.
REQ-010 When wbm_ack_i is sampled high in XFER, the block SHALL:
- pop the FIFO;
- increment the index and words_done_o;
- move to GAP, which deasserts cyc and stb on the next edge.
REQ-011 GAP SHALL last exactly one cycle with cyc and stb low, so the slave's negedge-registered ack can clear. It SHALL then go to DONE if index == NUM_WORDS, else to FETCH.
REQ-012 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-013 wbm_ack_i outside XFER SHALL be ignored.
REQ-014 busy_o SHALL be 1 in FETCH, XFER and GAP, and 0 in IDLE and DONE.
REQ-015 When cyc is low, wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o SHALL be 0.
REQ-016 The index SHALL be 4 bits plus a terminal compare. The address SHALL never exceed BASE_ADDR + 4*(NUM_WORDS-1).
REQ-017 FIFO words left over after DONE SHALL be kept for the next load.

Reset
REQ-018 On wb_rst_i the block SHALL:
- enter IDLE;
- empty the FIFO;
- zero the index and words_done_o;
- drive every Wishbone output, done_o, err_o and busy_o to 0;
- drive push_ready_o to 1 on the first cycle after reset.
REQ-019 Reset during XFER SHALL drop cyc and stb on the same edge with no further pop.

Configuration
REQ-020 Macro WEIGHT_LOADER_TIMEOUT_EN defined: a counter SHALL clear on entry to XFER and count each XFER cycle without ack. When it reaches TIMEOUT_CYCLES, the block SHALL:
- deassert cyc and stb;
- set err_o (sticky until the next accepted start_i or reset);
- leave the FIFO head unpopped;
- return to IDLE without pulsing done_o.
REQ-021 Macro undefined: XFER SHALL wait indefinitely, err_o SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-022 Push 16 words 32'h0000_0000..32'h0000_000F, pulse start_i, slave acks one cycle after stb -> 16 writes to 32'h30003000..32'h3000303C with matching data, sel 4'hF, done_o high one cycle, words_done_o = 16.
REQ-023 Push 5 words with no start -> push_ready_o drops after the 4th word, the 5th push is refused, count = 4, no bus activity.
REQ-024 Start with an empty FIFO, then push one word per 10 cycles -> FSM waits in FETCH, one write per pushed word, cyc low at least 1 cycle between writes.
REQ-025 WEIGHT_LOADER_TIMEOUT_EN defined, slave never acks -> cyc drops after 15 XFER cycles, err_o = 1, done_o stays 0, FIFO count unchanged; a new start_i clears err_o.
REQ-026 Assert wb_rst_i while stb is high at word 7 -> all outputs 0 on the next edge, FIFO empty, words_done_o = 0, a following start plus 16 words completes normally.
REQ-027 Pulse start_i again at word 3 of an active load -> ignored, load finishes at 16 words with a single done_o pulse.
